// File: rtl/cpu6502_pkg.sv
// Shared 6502 core types: interrupt sources, sequencer states, datapath selects
// and default vector addresses. Used by the interrupt sequencer and the decoder.
package cpu6502_pkg;

  typedef enum logic [2:0] {
    SRC_NONE = 3'd0,
    SRC_RST  = 3'd1,
    SRC_NMI  = 3'd2,
    SRC_IRQ  = 3'd3,
    SRC_BRK  = 3'd4
  } int_src_e;

  typedef enum logic [3:0] {
    SEQ_RST_WAIT = 4'd0,
    SEQ_IDLE     = 4'd1,
    SEQ_T0       = 4'd2,
    SEQ_T1       = 4'd3,
    SEQ_T2       = 4'd4,
    SEQ_T3       = 4'd5,
    SEQ_T4       = 4'd6,
    SEQ_T5       = 4'd7,
    SEQ_T6       = 4'd8
  } seq_state_e;

  typedef enum logic [1:0] {
    ADDR_PC     = 2'd0,
    ADDR_STACK  = 2'd1,
    ADDR_VEC_LO = 2'd2,
    ADDR_VEC_HI = 2'd3
  } addr_sel_e;

  typedef enum logic [1:0] {
    PUSH_PCH  = 2'd0,
    PUSH_PCL  = 2'd1,
    PUSH_P    = 2'd2,
    PUSH_NONE = 2'd3
  } push_sel_e;

  localparam logic [15:0] DEF_NMI_VEC = 16'hFFFA;
  localparam logic [15:0] DEF_RST_VEC = 16'hFFFC;
  localparam logic [15:0] DEF_IRQ_VEC = 16'hFFFE;

  // Stack cycles are real writes except during reset, where they degrade to reads.
  function automatic logic is_write_cycle(input seq_state_e st, input int_src_e src);
    return ((st == SEQ_T2) || (st == SEQ_T3) || (st == SEQ_T4)) && (src != SRC_RST);
  endfunction

endpackage

// File: rtl/nmi_edge_detect.sv
// Pin synchronizers for NMI and IRQ, plus a one-cycle pulse on each synchronized
// NMI falling edge. IRQ is level sensitive, so only its synchronized level leaves.
module nmi_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic rst_n,
  input  logic nmi,
  input  logic irq,
  output logic nmi_fall,
  output logic irq_sync
);

  logic [SYNC_STAGES-1:0] nmi_sync_r;
  logic [SYNC_STAGES-1:0] irq_sync_r;
  logic                   nmi_prev_r;

  // Shift chains idle high so a pin already low at reset release still yields a fall.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      nmi_sync_r <= {SYNC_STAGES{1'b1}};
      irq_sync_r <= {SYNC_STAGES{1'b1}};
      nmi_prev_r <= 1'b1;
    end else begin
      nmi_sync_r[0] <= nmi;
      irq_sync_r[0] <= irq;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        nmi_sync_r[i] <= nmi_sync_r[i-1];
        irq_sync_r[i] <= irq_sync_r[i-1];
      end
      nmi_prev_r <= nmi_sync_r[SYNC_STAGES-1];
    end
  end

  assign nmi_fall = nmi_prev_r & ~nmi_sync_r[SYNC_STAGES-1];
  assign irq_sync = irq_sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/interrupt_sequencer.sv
// 6502 interrupt sequencer: arbitrates RST/NMI/IRQ/BRK at instruction boundaries
// and steers the datapath through the push / vector-fetch sequence.
module interrupt_sequencer
  import cpu6502_pkg::*;
#(
  parameter logic [15:0] NMI_VEC     = DEF_NMI_VEC,
  parameter logic [15:0] RST_VEC     = DEF_RST_VEC,
  parameter logic [15:0] IRQ_VEC     = DEF_IRQ_VEC,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        RST,
  input  logic        NMI,
  input  logic        IRQ,
  input  logic        Ready,
  input  logic        sync,
  input  logic        brk_req,
  input  logic        i_flag,
  output logic        int_active,
  output logic        inhibit_fetch,
  output logic [1:0]  addr_sel,
  output logic [15:0] vec_addr,
  output logic [1:0]  push_sel,
  output logic        rw,
  output logic        sp_dec,
  output logic        pc_inc,
  output logic        b_out,
  output logic        load_pcl,
  output logic        load_pch,
  output logic        set_i
);

  seq_state_e  state_r, state_s;
  int_src_e    src_r, src_s;
  logic [15:0] vec_r, vec_s;
  logic        nmi_pend_r, nmi_pend_s;
  logic        poll_block_r, poll_block_s;
  logic        nmi_fall, irq_sync, advance;

  nmi_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_pins (
    .clock    (clock),
    .rst_n    (RST),
    .nmi      (NMI),
    .irq      (IRQ),
    .nmi_fall (nmi_fall),
    .irq_sync (irq_sync)
  );

  // A pending NMI at the end of T4 hijacks an IRQ/BRK sequence onto the NMI vector.
  function automatic logic [15:0] pick_vector(input int_src_e src, input logic pend);
    case (src)
      SRC_RST: return RST_VEC;
      SRC_NMI: return NMI_VEC;
      default: return pend ? NMI_VEC : IRQ_VEC;
    endcase
  endfunction

  // Sequencer state, source, latched vector and NMI/poll bookkeeping.
  always_ff @(posedge clock or negedge RST) begin
    if (!RST) begin
      state_r      <= SEQ_RST_WAIT;
      src_r        <= SRC_RST;
      vec_r        <= RST_VEC;
      nmi_pend_r   <= 1'b0;
      poll_block_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      src_r        <= src_s;
      vec_r        <= vec_s;
      nmi_pend_r   <= nmi_pend_s;
      poll_block_r <= poll_block_s;
    end
  end

  // Next-state and datapath controls; Ready only stalls read cycles.
  always_comb begin
    state_s       = state_r;
    src_s         = src_r;
    vec_s         = vec_r;
    poll_block_s  = poll_block_r;
    nmi_pend_s    = nmi_pend_r | nmi_fall;
    int_active    = 1'b1;
    inhibit_fetch = 1'b0;
    addr_sel      = ADDR_PC;
    vec_addr      = vec_r;
    push_sel      = PUSH_NONE;
    rw            = 1'b1;
    sp_dec        = 1'b0;
    pc_inc        = 1'b0;
    b_out         = 1'b0;
    load_pcl      = 1'b0;
    load_pch      = 1'b0;
    set_i         = 1'b0;
    advance       = Ready | is_write_cycle(state_r, src_r);

    case (state_r)
      SEQ_RST_WAIT: state_s = SEQ_T0;
      SEQ_IDLE: begin
        int_active = 1'b0;
        if (sync && Ready) begin
          if (poll_block_r) begin
            poll_block_s = 1'b0;
          end else if (nmi_pend_r) begin
            src_s = SRC_NMI;  inhibit_fetch = 1'b1;  state_s = SEQ_T1;
          end else if (!irq_sync && !i_flag) begin
            src_s = SRC_IRQ;  inhibit_fetch = 1'b1;  state_s = SEQ_T1;
          end else if (brk_req) begin
            src_s = SRC_BRK;  state_s = SEQ_T1;
          end else begin
            state_s = SEQ_IDLE;
          end
        end else begin
          state_s = SEQ_IDLE;
        end
      end
      SEQ_T0: begin
        if (Ready) state_s = SEQ_T1;
        else       state_s = SEQ_T0;
      end
      SEQ_T1: begin
        if (Ready) begin
          pc_inc  = (src_r == SRC_BRK);
          state_s = SEQ_T2;
        end else begin
          state_s = SEQ_T1;
        end
      end
      SEQ_T2, SEQ_T3, SEQ_T4: begin
        addr_sel = ADDR_STACK;
        b_out    = (state_r == SEQ_T4) && (src_r == SRC_BRK);
        if (src_r != SRC_RST) begin
          rw       = 1'b0;
          push_sel = (state_r == SEQ_T2) ? PUSH_PCH :
                     (state_r == SEQ_T3) ? PUSH_PCL : PUSH_P;
        end else begin
          rw = 1'b1;
        end
        if (advance) begin
          sp_dec  = 1'b1;
          state_s = (state_r == SEQ_T2) ? SEQ_T3 :
                    (state_r == SEQ_T3) ? SEQ_T4 : SEQ_T5;
          if (state_r == SEQ_T4) vec_s = pick_vector(src_r, nmi_pend_r);
          else                   vec_s = vec_r;
        end else begin
          state_s = state_r;
        end
      end
      SEQ_T5: begin
        addr_sel = ADDR_VEC_LO;
        vec_addr = vec_r;
        if (Ready) begin
          load_pcl = 1'b1;
          set_i    = 1'b1;
          state_s  = SEQ_T6;
          // A fresh edge landing on the clearing cycle must not be lost.
          if (vec_r == NMI_VEC) nmi_pend_s = nmi_fall;
          else                  nmi_pend_s = nmi_pend_r | nmi_fall;
        end else begin
          state_s = SEQ_T5;
        end
      end
      SEQ_T6: begin
        addr_sel = ADDR_VEC_HI;
        vec_addr = vec_r + 16'd1;
        if (Ready) begin
          load_pch     = 1'b1;
          poll_block_s = 1'b1;
          state_s      = SEQ_IDLE;
        end else begin
          state_s = SEQ_T6;
        end
      end
      default: state_s = SEQ_RST_WAIT;
    endcase
  end

endmodule
